// File: rtl/relu_requant_streamer.sv
// relu_requant_streamer
//   Requantizes 128-bit ReLU beats (four LANE_WIDTH-bit lanes) to bytes with a
//   runtime rounding right shift and saturation. It packs four beats into one
//   128-bit word and buffers words in a first-word-fall-through FIFO that feeds
//   a ready/valid stream carrying a frame-last marker.
//
//   Optional build macro RELU_REQUANT_SIGNED_EN:
//     defined   -> signed int8 output: arithmetic rounding shift, saturate to [-128, 127]
//     undefined -> unsigned output: x <= 0 gives 0, saturate to 255
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   shift_amt [4:0]      right shift, sampled with each accepted beat
//   in_valid, in_data    input beat strobe and four lanes (lane j = bits [32j+31:32j])
//   m_tvalid/m_tready    output handshake
//   m_tdata, m_tlast     head-of-FIFO word and its frame-last flag
//   frame_done           one-cycle pulse when a frame's last word is written or dropped
//   overflow             sticky drop flag; clear_ovf clears it (a new drop wins)
module relu_requant_streamer #(
   parameter int unsigned LANE_WIDTH  = 32,
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned FRAME_BEATS = 16384
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4:0]              shift_amt,
   input  logic                    in_valid,
   input  logic [4*LANE_WIDTH-1:0] in_data,
   output logic                    m_tvalid,
   input  logic                    m_tready,
   output logic [127:0]            m_tdata,
   output logic                    m_tlast,
   output logic                    frame_done,
   output logic                    overflow,
   input  logic                    clear_ovf
);

   localparam int unsigned FrameWords = FRAME_BEATS / 4;
   localparam int unsigned WcW        = (FrameWords > 1) ? $clog2(FrameWords) : 1;
   localparam int unsigned Aw         = $clog2(FIFO_DEPTH);
   localparam int unsigned Cw         = Aw + 1;

   localparam logic signed [LANE_WIDTH:0] One   = 1;
`ifdef RELU_REQUANT_SIGNED_EN
   localparam logic signed [LANE_WIDTH:0] SatHi = 127;
   localparam logic signed [LANE_WIDTH:0] SatLo = -128;
`else
   localparam logic signed [LANE_WIDTH:0] SatHi = 255;
`endif

   // One extra bit for the rounding add, so it cannot wrap.
   function automatic logic [7:0] quant(input logic [LANE_WIDTH-1:0] x, input logic [4:0] sh);
      logic signed [LANE_WIDTH:0] rnd;
      logic signed [LANE_WIDTH:0] sum;
      logic signed [LANE_WIDTH:0] r;
      rnd = (sh == 5'd0) ? '0 : (One <<< (sh - 5'd1));
`ifdef RELU_REQUANT_SIGNED_EN
      sum = $signed({x[LANE_WIDTH-1], x}) + rnd;
      r   = sum >>> sh;
      if (r > SatHi)      quant = 8'h7f;
      else if (r < SatLo) quant = 8'h80;
      else                quant = r[7:0];
`else
      sum = $signed({1'b0, x}) + rnd;
      r   = sum >>> sh;
      if (x[LANE_WIDTH-1] || (x == '0)) quant = 8'h00;
      else if (r > SatHi)               quant = 8'hff;
      else                              quant = r[7:0];
`endif
   endfunction

   // ---------------- stage 1: quantize ----------------
   logic [7:0] q_bytes [4];
   logic       s1_valid_q;
   logic [7:0] s1_bytes_q [4];

   always_comb begin
      for (int j = 0; j < 4; j++) begin
         q_bytes[j] = quant(in_data[j*LANE_WIDTH +: LANE_WIDTH], shift_amt);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         for (int j = 0; j < 4; j++) s1_bytes_q[j] <= '0;
      end else begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            for (int j = 0; j < 4; j++) s1_bytes_q[j] <= q_bytes[j];
         end
      end
   end

   // ---------------- stage 2: pack ----------------
   logic [1:0]     k_q;
   logic [127:0]   pack_q;
   logic [127:0]   pack_d;
   logic           push_q;
   logic [127:0]   push_data_q;
   logic           push_last_q;
   logic [WcW-1:0] wcnt_q;
   logic           word_last;
   logic           word_done;

   always_comb begin
      pack_d = pack_q;
      for (int j = 0; j < 4; j++) begin
         pack_d[{k_q, j[1:0], 3'b000} +: 8] = s1_bytes_q[j];
      end
   end

   assign word_last = (wcnt_q == WcW'(FrameWords - 1));
   assign word_done = s1_valid_q && (k_q == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_q         <= '0;
         pack_q      <= '0;
         push_q      <= 1'b0;
         push_data_q <= '0;
         push_last_q <= 1'b0;
         wcnt_q      <= '0;
      end else begin
         push_q <= word_done;
         if (s1_valid_q) begin
            pack_q <= pack_d;
            k_q    <= k_q + 2'd1;
         end
         // Word counter advances even if the FIFO later drops the word,
         // keeping tlast aligned with frame boundaries.
         if (word_done) begin
            push_data_q <= pack_d;
            push_last_q <= word_last;
            wcnt_q      <= word_last ? '0 : wcnt_q + 1'b1;
         end
      end
   end

   // ---------------- FIFO (first-word-fall-through) ----------------
   logic [128:0]  mem_q [FIFO_DEPTH];
   logic [Aw-1:0] wr_ptr_q;
   logic [Aw-1:0] rd_ptr_q;
   logic [Cw-1:0] count_q;
   logic          full;
   logic          pop;
   logic          push_ok;
   logic          drop;
   logic          frame_done_q;
   logic          overflow_q;

   assign full    = (count_q == Cw'(FIFO_DEPTH));
   assign pop     = m_tvalid && m_tready;
   assign push_ok = push_q && (!full || pop);
   assign drop    = push_q && full && !pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= {push_last_q, push_data_q};
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push_ok && !pop)      count_q <= count_q + 1'b1;
         else if (!push_ok && pop) count_q <= count_q - 1'b1;
         frame_done_q <= push_q && push_last_q;
         if (drop)           overflow_q <= 1'b1;
         else if (clear_ovf) overflow_q <= 1'b0;
      end
   end

   assign m_tvalid   = (count_q != '0);
   assign m_tdata    = mem_q[rd_ptr_q][127:0];
   assign m_tlast    = m_tvalid && mem_q[rd_ptr_q][128];
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_relu_requant_streamer.sv
// Directed bench for relu_requant_streamer (FIFO_DEPTH = 4, FRAME_BEATS = 8, i.e. two
// words per frame). Expected words are kept in a queue together with their tlast flag.
module tb_relu_requant_streamer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [4:0]   shift_amt;
   logic         in_valid;
   logic [127:0] in_data;
   logic         m_tvalid;
   logic         m_tready;
   logic [127:0] m_tdata;
   logic         m_tlast;
   logic         frame_done;
   logic         overflow;
   logic         clear_ovf;

   int n_checks = 0;
   int n_fail   = 0;
   int fd_cnt   = 0;
   int fd_before;
   bit widx     = 1'b0;   // index of next word within its two-word frame
   logic [128:0] exp_q [$];
   logic [128:0] head;

   relu_requant_streamer #(
      .LANE_WIDTH (32),
      .FIFO_DEPTH (4),
      .FRAME_BEATS(8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .shift_amt (shift_amt),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .m_tvalid  (m_tvalid),
      .m_tready  (m_tready),
      .m_tdata   (m_tdata),
      .m_tlast   (m_tlast),
      .frame_done(frame_done),
      .overflow  (overflow),
      .clear_ovf (clear_ovf)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_done) fd_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] exp_word(input int base);
      logic [127:0] w;
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 4; j++) w[8*(4*k+j) +: 8] = 8'(base + k);
      return w;
   endfunction

   // Drive one beat; returns 1 time unit after the sampling edge.
   task automatic beat(input logic [127:0] d, input logic [4:0] sh);
      shift_amt = sh;
      in_valid  = 1'b1;
      in_data   = d;
      @(posedge clk); #1;
      in_valid  = 1'b0;
   endtask

   // Four beats, beat k with every lane = base + k, shift 0.
   task automatic send_word(input int base);
      for (int k = 0; k < 4; k++) beat({4{32'(base + k)}}, 5'd0);
   endtask

   task automatic push_exp(input logic [127:0] w);
      exp_q.push_back({widx, w});
      widx = ~widx;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   // Pop everything with m_tready high; compare against the queue and count words.
   task automatic drain(input string tag, input int n_exp);
      int got;
      logic [128:0] e;
      got = 0;
      m_tready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (m_tvalid) begin
            got++;
            if (exp_q.size() == 0) begin
               check({tag, "_extra"}, 128'(got), 128'(n_exp));
            end else begin
               e = exp_q.pop_front();
               check({tag, "_data"}, m_tdata, e[127:0]);
               check({tag, "_last"}, 128'(m_tlast), 128'(e[128]));
            end
         end
      end
      @(posedge clk); #1;
      m_tready = 1'b0;
      check({tag, "_count"}, 128'(got), 128'(n_exp));
   endtask

   initial begin
      rst_n = 1'b0; shift_amt = '0; in_valid = 1'b0; in_data = '0;
      m_tready = 1'b0; clear_ovf = 1'b0;
      #12;
      check("rst_tvalid", 128'(m_tvalid), 128'(0));
      check("rst_tdata", m_tdata, 128'(0));
      check("rst_tlast", 128'(m_tlast), 128'(0));
      check("rst_frame_done", 128'(frame_done), 128'(0));
      check("rst_overflow", 128'(overflow), 128'(0));
      #11 rst_n = 1'b1;
      @(posedge clk); #1;

      // Unsigned rounding, shift 4: lanes {0x17, 0x18, 0xFFF, -5} -> {01, 02, FF, 00}
      m_tready = 1'b1;
      for (int k = 0; k < 4; k++)
         beat({32'hFFFF_FFFB, 32'h0000_0FFF, 32'h0000_0018, 32'h0000_0017}, 5'd4);
      check("lat_e0", 128'(m_tvalid), 128'(0));
      @(posedge clk); #1;
      check("lat_e1", 128'(m_tvalid), 128'(0));
      @(posedge clk); #1;
      check("lat_e2", 128'(m_tvalid), 128'(1));
      check("round_data", m_tdata, {4{32'h00FF_0201}});
      check("round_last", 128'(m_tlast), 128'(0));
      check("round_fd", 128'(frame_done), 128'(0));
      widx = ~widx;

      // Byte placement, shift 0: beat k lanes {4k..4k+3}; second word of frame
      for (int k = 0; k < 4; k++)
         beat({32'(4*k+3), 32'(4*k+2), 32'(4*k+1), 32'(4*k)}, 5'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("place_data", m_tdata, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
      check("place_last", 128'(m_tlast), 128'(1));
      check("place_fd", 128'(frame_done), 128'(1));
      widx = ~widx;
      @(posedge clk); #1;
      check("place_fd_end", 128'(frame_done), 128'(0));
      check("place_popped", 128'(m_tvalid), 128'(0));
      m_tready = 1'b0;

      // Frame boundary: 16 continuous beats = two frames
      fd_before = fd_cnt;
      for (int w = 0; w < 4; w++) begin
         send_word(16 + 4*w);
         push_exp(exp_word(16 + 4*w));
      end
      drain("frame", 4);
      check("frame_fd_pulses", 128'(fd_cnt - fd_before), 128'(2));

      // Requant of mixed values with shift 1
      for (int k = 0; k < 4; k++)
         beat({32'd256, 32'hFFFF_FFFD, 32'd300, 32'hFFFF_FED4}, 5'd1);
`ifdef RELU_REQUANT_SIGNED_EN
      push_exp({4{32'h7FFF_7F80}});
`else
      push_exp({4{32'h8000_9600}});
`endif
      drain("shift1", 1);

      // Backpressure and overflow
      for (int w = 0; w < 4; w++) begin
         send_word(40 + 4*w);
         push_exp(exp_word(40 + 4*w));
      end
      idle(4);
      check("ovf_pre", 128'(overflow), 128'(0));
      send_word(56);
      widx = ~widx;   // dropped, counter still advances
      idle(4);
      check("ovf_set", 128'(overflow), 128'(1));
      drain("bp", 4);
      check("ovf_sticky", 128'(overflow), 128'(1));
      clear_ovf = 1'b1;
      @(posedge clk); #1;
      clear_ovf = 1'b0;
      check("ovf_clear", 128'(overflow), 128'(0));

      // Full FIFO with push and pop on the same edge
      for (int w = 0; w < 4; w++) begin
         send_word(60 + 4*w);
         push_exp(exp_word(60 + 4*w));
      end
      idle(4);
      send_word(76);
      head = exp_q.pop_front();
      check("sp_head", m_tdata, head[127:0]);
      @(posedge clk); #1;
      m_tready = 1'b1;
      @(posedge clk); #1;
      m_tready = 1'b0;
      push_exp(exp_word(76));
      idle(3);
      check("sp_no_ovf", 128'(overflow), 128'(0));
      drain("sp", 4);

      // Reset mid-frame
      for (int w = 0; w < 5; w++) send_word(80 + 4*w);
      beat({4{32'd100}}, 5'd0);
      beat({4{32'd101}}, 5'd0);
      check("pre_rst_ovf", 128'(overflow), 128'(1));
      check("pre_rst_tvalid", 128'(m_tvalid), 128'(1));
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_tvalid", 128'(m_tvalid), 128'(0));
      check("mid_rst_tdata", m_tdata, 128'(0));
      check("mid_rst_tlast", 128'(m_tlast), 128'(0));
      check("mid_rst_fd", 128'(frame_done), 128'(0));
      check("mid_rst_ovf", 128'(overflow), 128'(0));
      #2 rst_n = 1'b1;
      exp_q.delete();
      widx = 1'b0;
      @(posedge clk); #1;
      send_word(120);
      push_exp(exp_word(120));
      send_word(124);
      push_exp(exp_word(124));
      drain("post_rst", 2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
